// File: rtl/cpu_mem_arbiter.sv
// Shares one memory request/response port between the CPU instruction and data
// sides, serving requests captured in IDLE in fixed D, W, I order while stalling the CPU.
module cpu_mem_arbiter #(
  parameter int          AWIDTH     = 32,
  parameter logic [31:0] RESET_INST = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       icache_addr,
  input  logic              icache_re,
  input  logic [3:0]        icache_we,
  input  logic [31:0]       icache_din,
  input  logic [31:0]       dcache_addr,
  input  logic              dcache_re,
  input  logic [3:0]        dcache_we,
  input  logic [31:0]       dcache_din,
  output logic [31:0]       instruction,
  output logic [31:0]       dcache_dout,
  output logic              stall,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [AWIDTH-1:0] mem_req_addr,
  output logic [3:0]        mem_req_we,
  output logic [31:0]       mem_req_wdata,
  input  logic              mem_resp_valid,
  input  logic [31:0]       mem_resp_data
);

  typedef enum logic [2:0] {IDLE, D_REQ, D_WAIT, W_REQ, I_REQ, I_WAIT} state_t;

  state_t            state_q, state_d, after_d;
  logic [AWIDTH-3:0] d_addr_q, d_addr_d, i_addr_q, i_addr_d;
  logic [3:0]        d_we_q, d_we_d, i_we_q, i_we_d;
  logic [31:0]       d_din_q, d_din_d, i_din_q, i_din_d;
  logic              pw_q, pw_d, pi_q, pi_d;
  logic [31:0]       inst_q, inst_d, dout_q, dout_d;

  // Memory is word addressed; the byte offset never leaves this block.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{icache_addr[1:0], dcache_addr[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    after_d = pw_q ? W_REQ : (pi_q ? I_REQ : IDLE);
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (dcache_re || (|dcache_we)) state_d = D_REQ;
        else if (|icache_we)           state_d = W_REQ;
        else if (icache_re)            state_d = I_REQ;
      end
      D_REQ:  if (mem_req_ready)  state_d = (|d_we_q) ? after_d : D_WAIT;
      D_WAIT: if (mem_resp_valid) state_d = after_d;
      W_REQ:  if (mem_req_ready)  state_d = pi_q ? I_REQ : IDLE;
      I_REQ:  if (mem_req_ready)  state_d = I_WAIT;
      I_WAIT: if (mem_resp_valid) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req_valid = 1'b0;
    mem_req_we    = 4'h0;
    mem_req_addr  = '0;
    mem_req_wdata = 32'h0;
    inst_d        = inst_q;
    dout_d        = dout_q;
    case (state_q)
      D_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {d_addr_q, 2'b00};
        mem_req_we    = d_we_q;
        mem_req_wdata = d_din_q;
      end
      W_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {i_addr_q, 2'b00};
        mem_req_we    = i_we_q;
        mem_req_wdata = i_din_q;
      end
      I_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {i_addr_q, 2'b00};
      end
      D_WAIT: if (mem_resp_valid) dout_d = mem_resp_data;
      I_WAIT: if (mem_resp_valid) inst_d = mem_resp_data;
      default: ;
    endcase
  end

  // Requests are sampled only while idle; re-presented copies during stall are ignored.
  always_comb begin
    d_addr_d = d_addr_q;
    d_we_d   = d_we_q;
    d_din_d  = d_din_q;
    i_addr_d = i_addr_q;
    i_we_d   = i_we_q;
    i_din_d  = i_din_q;
    pw_d     = pw_q;
    pi_d     = pi_q;
    if (state_q == IDLE) begin
      d_addr_d = dcache_addr[AWIDTH-1:2];
      d_we_d   = dcache_we;
      d_din_d  = dcache_din;
      i_addr_d = icache_addr[AWIDTH-1:2];
      i_we_d   = icache_we;
      i_din_d  = icache_din;
      pw_d     = |icache_we;
      pi_d     = icache_re;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_addr_q <= '0;
      d_we_q   <= 4'h0;
      d_din_q  <= 32'h0;
      i_addr_q <= '0;
      i_we_q   <= 4'h0;
      i_din_q  <= 32'h0;
      pw_q     <= 1'b0;
      pi_q     <= 1'b0;
      inst_q   <= RESET_INST;
      dout_q   <= 32'h0;
    end else begin
      d_addr_q <= d_addr_d;
      d_we_q   <= d_we_d;
      d_din_q  <= d_din_d;
      i_addr_q <= i_addr_d;
      i_we_q   <= i_we_d;
      i_din_q  <= i_din_d;
      pw_q     <= pw_d;
      pi_q     <= pi_d;
      inst_q   <= inst_d;
      dout_q   <= dout_d;
    end
  end

  assign stall       = (state_q != IDLE);
  assign instruction = inst_q;
  assign dcache_dout = dout_q;

endmodule
